cmp16_seq: RTL and testbench
============================

CMP16_SEQ -- requirements
Module: cmp16_seq

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, setting operand width to 4*NIBBLES bits (minimum 2).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 sysclk  in  1  system clock; all state changes on rising edge.
REQ-004 sys_rst_n  in  1  asynchronous active-low reset.
REQ-005 start_i  in  1  request a compare; sampled only in IDLE.
REQ-006 signed_i  in  1  1 = two's-complement compare, 0 = unsigned; captured with operands.
REQ-007 a_i  in  4*NIBBLES  operand A; captured on accepted start.
REQ-008 b_i  in  4*NIBBLES  operand B; captured on accepted start.
REQ-009 cmp_a_o  out  4  nibble of A driven to the external CMP4 A0..A3.
REQ-010 cmp_b_o  out  4  nibble of B driven to the external CMP4 B0..B3.
REQ-011 cmp_aeb_i, cmp_agb_i, cmp_alb_i  in  1 each  CMP4 AEB/AGB/ALB, same-cycle combinational response to cmp_a_o/cmp_b_o.
REQ-012 busy_o  out  1  high from the cycle after an accepted start until DONE is left.
REQ-013 done_o  out  1  one-cycle pulse; results valid.
REQ-014 aeb_o, agb_o, alb_o  out  1 each  registered final result, one-hot after a valid compare.
REQ-015 err_o  out  1  sticky flag: CMP4 result was not one-hot during a compare.

Function
REQ-016 FSM states SHALL be IDLE, SCAN, DONE.
REQ-017 In IDLE with start_i=1, the block SHALL capture a_i, b_i and signed_i, clear err_o, set nibble index to NIBBLES-1, and enter SCAN.
REQ-018 start_i in SCAN or DONE SHALL be ignored (not queued).
REQ-019 In SCAN, cmp_a_o/cmp_b_o SHALL carry the captured nibble at the current index, MSB nibble first.
REQ-020 Bit 3 of both driven nibbles SHALL be inverted, except for the top nibble when the captured signed flag is 1, so the signed CMP4 yields unsigned ordering.
REQ-021 Each SCAN cycle SHALL sample cmp_*_i: if AEB=0, or the index is 0, latch the sampled AEB/AGB/ALB into aeb_o/agb_o/alb_o and enter DONE; otherwise decrement the index and stay in SCAN.
REQ-022 A non-one-hot cmp_*_i triple in any SCAN cycle SHALL set err_o; that sample SHALL be treated as unequal and latched as-is.
REQ-023 Latency: the first differing nibble at index k SHALL give done_o NIBBLES-k+1 cycles after the start edge; equal operands SHALL give NIBBLES+1 cycles (5 for NIBBLES=4).
REQ-024 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-025 aeb_o/agb_o/alb_o SHALL hold their value until the next compare latches new values.
REQ-026 In IDLE and DONE, cmp_a_o and cmp_b_o SHALL be driven 0.

Reset
REQ-027 Asserted sys_rst_n SHALL immediately force IDLE, index 0, busy_o=0, done_o=0, aeb_o=0, agb_o=0, alb_o=0, err_o=0, and clear the operand registers.
REQ-028 Reset asserted mid-SCAN SHALL abort the compare with no done_o pulse.
REQ-029 The first start after reset release SHALL behave as a normal start.

Structure
REQ-030 The state encoding and the default NIBBLES constant SHALL live in shared package cmp_seq_pkg.
REQ-031 The block SHALL contain no sub-module; the CMP4 instance SHALL be placed by the parent and wired to the cmp_* ports.

Verification
REQ-032 NIBBLES=4, unsigned, A=0x1234, B=0x1234 -> done_o 5 cycles after start; aeb_o=1, agb_o=0, alb_o=0.
REQ-033 Unsigned, A=0x8000, B=0x0001 -> done_o 2 cycles after start; agb_o=1. Same operands signed -> alb_o=1.
REQ-034 Signed, A=0xFFFF, B=0xFFFE -> done_o 5 cycles after start; agb_o=1. Check cmp_a_o=0x7 on the last nibble.
REQ-035 Pulse start_i again 1 cycle after an accepted start -> ignored; exactly one done_o, busy_o low after DONE.
REQ-036 Assert sys_rst_n low in the 2nd SCAN cycle -> all outputs 0 immediately, no done_o; next compare is correct.
REQ-037 Force cmp_agb_i=cmp_alb_i=1 on the first nibble -> err_o=1, done_o after 2 cycles; err_o clears on the next start.

Source files
------------

// File: rtl/cmp16_seq_pkg.sv
// Shared definitions for the sequential nibble comparator.
//   DEF_NIBBLES  default operand width in nibbles
//   state_t      controller state encoding
//   is_onehot3   true when exactly one of {aeb, agb, alb} is set
//   bias_nibble  flips bit 3 so a signed 4-bit comparator orders the nibble
//                as unsigned; keep_sign leaves it untouched (signed top nibble)
package cmp_seq_pkg;

   localparam int DEF_NIBBLES = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_onehot3(input logic [2:0] v);
      return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
   endfunction

   function automatic logic [3:0] bias_nibble(input logic [3:0] nib, input logic keep_sign);
      return keep_sign ? nib : {~nib[3], nib[2:0]};
   endfunction

endpackage

// File: rtl/cmp16_seq_if.sv
// Bundle between cmp16_seq and its parent.
//   request : start_i, signed_i, a_i, b_i
//   status  : busy_o, done_o, aeb_o, agb_o, alb_o, err_o
//   CMP4    : cmp_a_o, cmp_b_o (to comparator), cmp_aeb_i/agb_i/alb_i (from it)
// slave  = the sequencer, master = the parent (requester + CMP4 wiring).
interface cmp16_seq_if
   import cmp_seq_pkg::*;
   #(parameter int NIBBLES = DEF_NIBBLES) ();

   logic                 start_i;
   logic                 signed_i;
   logic [4*NIBBLES-1:0] a_i;
   logic [4*NIBBLES-1:0] b_i;
   logic [3:0]           cmp_a_o;
   logic [3:0]           cmp_b_o;
   logic                 cmp_aeb_i;
   logic                 cmp_agb_i;
   logic                 cmp_alb_i;
   logic                 busy_o;
   logic                 done_o;
   logic                 aeb_o;
   logic                 agb_o;
   logic                 alb_o;
   logic                 err_o;

   modport slave (
      input  start_i, signed_i, a_i, b_i,
      input  cmp_aeb_i, cmp_agb_i, cmp_alb_i,
      output cmp_a_o, cmp_b_o,
      output busy_o, done_o, aeb_o, agb_o, alb_o, err_o
   );

   modport master (
      output start_i, signed_i, a_i, b_i,
      output cmp_aeb_i, cmp_agb_i, cmp_alb_i,
      input  cmp_a_o, cmp_b_o,
      input  busy_o, done_o, aeb_o, agb_o, alb_o, err_o
   );

endinterface

// File: rtl/cmp16_seq.sv
// Sequential magnitude comparator built around one external 4-bit CMP4.
// Operands are walked MSB nibble first; the first unequal nibble (or the
// last one) decides the result.
//   sysclk     system clock
//   sys_rst_n  asynchronous active-low reset
//   bus        cmp16_seq_if.slave (request, status and CMP4 wiring)
//
// state | meaning
// IDLE  | waiting for start_i, CMP4 inputs driven 0
// SCAN  | one nibble per cycle presented to CMP4, response sampled
// DONE  | one-cycle done_o pulse, results valid
module cmp16_seq
   import cmp_seq_pkg::*;
   #(parameter int NIBBLES = DEF_NIBBLES)
   (
      input logic         sysclk,
      input logic         sys_rst_n,
      cmp16_seq_if.slave  bus
   );

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NIBBLES - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             sgn_q, sgn_d;
   logic             err_q, err_d;
   logic [2:0]       res_q, res_d;

   logic [3:0]       nib_a, nib_b;
   logic [3:0]       cmp_a, cmp_b;
   logic [2:0]       smp;
   logic             smp_ok;
   logic             keep_sign;

   assign nib_a     = a_q[4*idx_q +: 4];
   assign nib_b     = b_q[4*idx_q +: 4];
   // Only the top nibble of a signed compare keeps its sign bit.
   assign keep_sign = sgn_q && (idx_q == TOP_IDX);
   assign smp       = {bus.cmp_aeb_i, bus.cmp_agb_i, bus.cmp_alb_i};
   assign smp_ok    = is_onehot3(smp);

   always_ff @(posedge sysclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         err_q   <= 1'b0;
         res_q   <= 3'b000;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         err_q   <= err_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      err_d   = err_q;
      res_d   = res_q;
      cmp_a   = 4'h0;
      cmp_b   = 4'h0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start_i) begin
               a_d     = bus.a_i;
               b_d     = bus.b_i;
               sgn_d   = bus.signed_i;
               err_d   = 1'b0;
               idx_d   = TOP_IDX;
               state_d = ST_SCAN;
            end
         end

         ST_SCAN: begin
            cmp_a = bias_nibble(nib_a, keep_sign);
            cmp_b = bias_nibble(nib_b, keep_sign);
            if (!smp_ok) begin
               err_d = 1'b1;
            end
            // A malformed response ends the scan as if unequal and is kept
            // verbatim so the parent can see what the CMP4 returned.
            if (!smp[2] || !smp_ok || (idx_q == '0)) begin
               res_d   = smp;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.cmp_a_o = cmp_a;
   assign bus.cmp_b_o = cmp_b;
   assign bus.busy_o  = (state_q != ST_IDLE);
   assign bus.done_o  = (state_q == ST_DONE);
   assign bus.aeb_o   = res_q[2];
   assign bus.agb_o   = res_q[1];
   assign bus.alb_o   = res_q[0];
   assign bus.err_o   = err_q;

endmodule

// File: tb/tb_cmp16_seq.sv
module tb_cmp16_seq;

   localparam int NIB = 4;

   logic clk;
   logic rst_n;
   logic fault_en;
   logic signed [3:0] m_a, m_b;

   int n_checks = 0;
   int n_fail   = 0;

   cmp16_seq_if #(.NIBBLES(NIB)) bus ();

   cmp16_seq #(.NIBBLES(NIB)) dut (
      .sysclk    (clk),
      .sys_rst_n (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External CMP4: a signed 4-bit comparator, optionally returning a
   // non-one-hot response.
   assign m_a = bus.cmp_a_o;
   assign m_b = bus.cmp_b_o;
   always_comb begin
      if (fault_en) begin
         bus.cmp_aeb_i = 1'b0;
         bus.cmp_agb_i = 1'b1;
         bus.cmp_alb_i = 1'b1;
      end else begin
         bus.cmp_aeb_i = (m_a == m_b);
         bus.cmp_agb_i = (m_a > m_b);
         bus.cmp_alb_i = (m_a < m_b);
      end
   end

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sgn;
      int          lat;
      logic [2:0]  res;
      logic [3:0]  la;
      logic [3:0]  lb;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: full-width compare, latency from the first differing nibble.
   function automatic void ref_cmp(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                                   output int lat, output logic [2:0] res);
      int k;
      k = -1;
      for (int i = NIB - 1; i >= 0; i--) begin
         if (k < 0 && a[4*i +: 4] != b[4*i +: 4]) k = i;
      end
      if (k < 0) begin
         lat = NIB + 1;
         res = 3'b100;
      end else begin
         lat = NIB - k + 1;
         if (sgn) res = ($signed(a) > $signed(b)) ? 3'b010 : 3'b001;
         else     res = (a > b) ? 3'b010 : 3'b001;
      end
   endfunction

   task automatic chk_all_zero(input string name);
      chk({name, "_busy"}, 32'(bus.busy_o), 32'd0);
      chk({name, "_done"}, 32'(bus.done_o), 32'd0);
      chk({name, "_res"},  32'({bus.aeb_o, bus.agb_o, bus.alb_o}), 32'd0);
      chk({name, "_err"},  32'(bus.err_o), 32'd0);
      chk({name, "_cmp"},  32'({bus.cmp_a_o, bus.cmp_b_o}), 32'd0);
   endtask

   // lat counts the accept cycle's successor as cycle 1; 20 means timeout.
   task automatic run_compare(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                              input logic fault, output int lat, output logic [2:0] res,
                              output logic err, output logic [3:0] la, output logic [3:0] lb);
      bus.a_i      = a;
      bus.b_i      = b;
      bus.signed_i = sgn;
      fault_en     = fault;
      bus.start_i  = 1'b1;
      step();
      bus.start_i  = 1'b0;
      lat = 1;
      la  = 4'h0;
      lb  = 4'h0;
      while (!bus.done_o && lat < 20) begin
         la = bus.cmp_a_o;
         lb = bus.cmp_b_o;
         step();
         lat++;
      end
      fault_en = 1'b0;
      if (!bus.done_o) $display("FAIL timeout: no done_o within %0d cycles", lat);
      res = {bus.aeb_o, bus.agb_o, bus.alb_o};
      err = bus.err_o;
      step();
      chk("done_one_cycle", 32'(bus.done_o), 32'd0);
      chk("busy_after_done", 32'(bus.busy_o), 32'd0);
   endtask

   initial begin
      int lat, exp_lat, dcount, dcyc;
      logic [2:0] res, exp_res;
      logic err;
      logic [3:0] la, lb;
      logic [15:0] ra, rb, keep;
      logic rs;
      int k;

      //           a         b         sgn   lat res     last a/b nibble
      vecs[0] = '{16'h1234, 16'h1234, 1'b0, 5, 3'b100, 4'hC, 4'hC};
      vecs[1] = '{16'h8000, 16'h0001, 1'b0, 2, 3'b010, 4'h0, 4'h8};
      vecs[2] = '{16'h8000, 16'h0001, 1'b1, 2, 3'b001, 4'h8, 4'h0};
      vecs[3] = '{16'hFFFF, 16'hFFFE, 1'b1, 5, 3'b010, 4'h7, 4'h6};
      vecs[4] = '{16'h0000, 16'hFFFF, 1'b1, 2, 3'b010, 4'h0, 4'hF};
      vecs[5] = '{16'h0000, 16'hFFFF, 1'b0, 2, 3'b001, 4'h8, 4'h7};
      vecs[6] = '{16'h1230, 16'h1240, 1'b0, 4, 3'b001, 4'hB, 4'hC};
      vecs[7] = '{16'h7FFF, 16'h8000, 1'b1, 2, 3'b010, 4'h7, 4'h8};
      vecs[8] = '{16'h1235, 16'h1234, 1'b1, 5, 3'b010, 4'hD, 4'hC};
      vecs[9] = '{16'hABCD, 16'hABCD, 1'b1, 5, 3'b100, 4'h5, 4'h5};

      fault_en     = 1'b0;
      bus.start_i  = 1'b0;
      bus.signed_i = 1'b0;
      bus.a_i      = '0;
      bus.b_i      = '0;
      rst_n        = 1'b0;
      step();
      step();
      chk_all_zero("reset");
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 10; i++) begin
         run_compare(vecs[i].a, vecs[i].b, vecs[i].sgn, 1'b0, lat, res, err, la, lb);
         chk($sformatf("vec%0d_lat", i),   32'(lat), 32'(vecs[i].lat));
         chk($sformatf("vec%0d_res", i),   32'(res), 32'(vecs[i].res));
         chk($sformatf("vec%0d_err", i),   32'(err), 32'd0);
         chk($sformatf("vec%0d_last", i),  32'({la, lb}), 32'({vecs[i].la, vecs[i].lb}));
      end

      // Results hold in IDLE until the next compare.
      step();
      step();
      chk("hold_res", 32'({bus.aeb_o, bus.agb_o, bus.alb_o}), 32'(vecs[9].res));

      for (int i = 0; i < 150; i++) begin
         ra = 16'($urandom);
         rs = 1'($urandom);
         k  = $urandom_range(0, 4);
         if (k == 4) begin
            rb = ra;
         end else begin
            keep = 16'hFFFF << (4 * (k + 1));
            rb = (ra & keep) | (16'($urandom) & ~keep);
         end
         ref_cmp(ra, rb, rs, exp_lat, exp_res);
         run_compare(ra, rb, rs, 1'b0, lat, res, err, la, lb);
         chk($sformatf("rnd%0d_lat a=%h b=%h s=%0d", i, ra, rb, rs), 32'(lat), 32'(exp_lat));
         chk($sformatf("rnd%0d_res a=%h b=%h s=%0d", i, ra, rb, rs), 32'(res), 32'(exp_res));
         chk($sformatf("rnd%0d_err", i), 32'(err), 32'd0);
      end

      // start_i during SCAN is dropped, not queued.
      bus.a_i      = 16'h1234;
      bus.b_i      = 16'h1234;
      bus.signed_i = 1'b0;
      bus.start_i  = 1'b1;
      step();
      bus.start_i  = 1'b1;
      dcount = 0;
      dcyc   = 0;
      for (int c = 2; c <= 14; c++) begin
         step();
         bus.start_i = 1'b0;
         if (bus.done_o) begin
            dcount++;
            if (dcyc == 0) dcyc = c;
         end
         if (c == 7) chk("ignore_busy_c7", 32'(bus.busy_o), 32'd0);
      end
      chk("ignore_done_count", 32'(dcount), 32'd1);
      chk("ignore_done_cycle", 32'(dcyc), 32'd5);
      chk("ignore_res", 32'({bus.aeb_o, bus.agb_o, bus.alb_o}), 32'b100);

      // Malformed CMP4 response on the first nibble.
      run_compare(16'h5000, 16'h5000, 1'b0, 1'b1, lat, res, err, la, lb);
      chk("fault_lat", 32'(lat), 32'd2);
      chk("fault_err", 32'(err), 32'd1);
      chk("fault_res", 32'(res), 32'b011);
      chk("fault_sticky", 32'(bus.err_o), 32'd1);
      run_compare(16'h0001, 16'h0002, 1'b0, 1'b0, lat, res, err, la, lb);
      chk("fault_clear_err", 32'(err), 32'd0);
      chk("fault_clear_res", 32'(res), 32'b001);
      chk("fault_clear_lat", 32'(lat), 32'd5);

      // Reset in the 2nd SCAN cycle aborts the compare.
      run_compare(16'h8000, 16'h0001, 1'b0, 1'b0, lat, res, err, la, lb);
      bus.a_i     = 16'h1234;
      bus.b_i     = 16'h1234;
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      step();
      chk("abort_busy_pre", 32'(bus.busy_o), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("abort");
      dcount = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (bus.done_o) dcount++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         if (bus.done_o) dcount++;
      end
      chk("abort_no_done", 32'(dcount), 32'd0);
      ref_cmp(16'hABCD, 16'hABCE, 1'b1, exp_lat, exp_res);
      run_compare(16'hABCD, 16'hABCE, 1'b1, 1'b0, lat, res, err, la, lb);
      chk("post_reset_lat", 32'(lat), 32'(exp_lat));
      chk("post_reset_res", 32'(res), 32'(exp_res));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
